// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// CTRL/STATUS bit positions and address-region decode.
package data_mem_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_COUNT  = 8'h04;
    localparam logic [7:0] OFF_CMP    = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_LED    = 8'h10;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_AUTO   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_TMR = 0;
    localparam int unsigned STAT_EXT = 1;

    localparam logic [3:0] RAM_TAG = 4'h0;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_MMIO
    } region_e;

    // page = addr[31:8]; mmio_page = MMIO_BASE[31:8]
    function automatic region_e decode_region(input logic [23:0] page,
                                              input logic [23:0] mmio_page);
        if (page[23:20] == RAM_TAG) return REGION_RAM;
        if (page == mmio_page)      return REGION_MMIO;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus plus the interrupt request/cause lines to CP0.
interface data_mem_responder_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        ir_in;
    logic        int_cause;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, ir_in, int_cause
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, ir_in, int_cause
    );
endinterface

// File: rtl/data_mem_responder_mmio_timer.sv
// Programmable timer: CTRL, COUNT and CMP registers with compare-match logic.
module mmio_timer
    import data_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        match,
    output logic        irq_en
);

    logic [2:0]  ctrl;
    logic [31:0] count;
    logic [31:0] cmp;

    assign match  = ctrl[CTRL_EN] && (count == cmp);
    assign irq_en = ctrl[CTRL_IRQ_EN];

    // CPU writes take precedence over the hardware enable-clear and count update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl  <= '0;
            count <= '0;
            cmp   <= '0;
        end else begin
            if (wr_en && off == OFF_CTRL)
                ctrl <= wdata[2:0];
            else if (match && !ctrl[CTRL_AUTO])
                ctrl[CTRL_EN] <= 1'b0;

            if (wr_en && off == OFF_CMP)
                cmp <= wdata;

            if (wr_en && off == OFF_COUNT)
                count <= wdata;
            else if (match) begin
                if (ctrl[CTRL_AUTO])
                    count <= '0;
            end else if (ctrl[CTRL_EN])
                count <= count + 32'd1;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:  rdata = {29'd0, ctrl};
            OFF_COUNT: rdata = count;
            OFF_CMP:   rdata = cmp;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, MMIO block (timer, STATUS, LED) and
// external-interrupt latch driving the CP0 interrupt request/cause.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus,
    input  logic                  ext_irq,
    output logic [15:0]           led
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    region_e            region;
    logic [7:0]         off;
    logic [RAM_AW-1:0]  ram_idx;
    logic               ram_wr;
    logic               mmio_wr;
    logic               unused_addr_bits;

    assign region           = decode_region(bus.mem_addr[31:8], MMIO_BASE[31:8]);
    assign off              = {bus.mem_addr[7:2], 2'b00};
    assign ram_idx          = bus.mem_addr[RAM_AW+1:2];
    assign ram_wr           = bus.mem_wen && (region == REGION_RAM);
    assign mmio_wr          = bus.mem_wen && (region == REGION_MMIO);
    assign unused_addr_bits = ^bus.mem_addr[1:0];

    logic [31:0] ram [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (ram_wr)
            ram[ram_idx] <= bus.mem_dout;
    end

    logic [31:0] timer_rdata;
    logic        timer_match;
    logic        timer_irq_en;

    mmio_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (mmio_wr),
        .off    (off),
        .wdata  (bus.mem_dout),
        .rdata  (timer_rdata),
        .match  (timer_match),
        .irq_en (timer_irq_en)
    );

    logic       ext_sync1;
    logic       ext_sync2;
    logic       ext_prev;
    logic       ext_rise;
    logic [1:0] status;
    logic [1:0] status_next;

    assign ext_rise = ext_sync2 && !ext_prev;

    // Hardware sets are applied after the W1C so they win in the same cycle.
    always_comb begin
        status_next = status;
        if (mmio_wr && off == OFF_STATUS)
            status_next = status & ~bus.mem_dout[1:0];
        if (timer_match)
            status_next[STAT_TMR] = 1'b1;
        if (ext_rise)
            status_next[STAT_EXT] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync1 <= 1'b0;
            ext_sync2 <= 1'b0;
            ext_prev  <= 1'b0;
            status    <= '0;
            led       <= '0;
        end else begin
            ext_sync1 <= ext_irq;
            ext_sync2 <= ext_sync1;
            ext_prev  <= ext_sync2;
            status    <= status_next;
            if (mmio_wr && off == OFF_LED)
                led <= bus.mem_dout[15:0];
        end
    end

    assign bus.ir_in     = status[STAT_EXT] | (status[STAT_TMR] & timer_irq_en);
    assign bus.int_cause = status[STAT_EXT];

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (region)
            REGION_RAM: rdata = ram[ram_idx];
            REGION_MMIO: begin
                case (off)
                    OFF_STATUS: rdata = {30'd0, status};
                    OFF_LED:    rdata = {16'd0, led};
                    default:    rdata = timer_rdata;
                endcase
            end
            default: rdata = '0;
        endcase
    end

    assign bus.mem_din = bus.mem_ren ? rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: scoreboarded RAM, arithmetic
// timer expectations, interrupt timing and reset behaviour.
module tb_data_mem_responder;

    localparam logic [31:0] A_CTRL   = 32'hFFFF_FF00;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CMP    = 32'hFFFF_FF08;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF0C;
    localparam logic [31:0] A_LED    = 32'hFFFF_FF10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_irq;
    logic [15:0] led;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] ram_model [int unsigned];

    data_mem_responder_if bus();

    data_mem_responder #(
        .RAM_AW    (10),
        .MMIO_BASE (32'hFFFF_FF00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .ext_irq (ext_irq),
        .led     (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b1;
        bus.mem_addr = a;
        bus.mem_dout = d;
        @(posedge clk);
        #1;
        bus.mem_wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.mem_ren  = 1'b1;
        bus.mem_addr = a;
        #1;
        d = bus.mem_din;
        bus.mem_ren = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0; ext_irq = 1'b0;
        bus.mem_ren = 1'b0; bus.mem_wen = 1'b0; bus.mem_addr = '0; bus.mem_dout = '0;
        tick(2);
        total++; if (led !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=0", led); end
        total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL reset_ir got=%b exp=0", bus.ir_in); end
        total++; if (bus.int_cause !== 1'b0) begin bad++; $display("FAIL reset_cause got=%b exp=0", bus.int_cause); end
        rd(A_COUNT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", d); end
        rd(A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_ram_basic();
        logic [31:0] d;
        wr(32'h0000_0040, 32'hDEAD_BEEF);
        ram_model[16] = 32'hDEAD_BEEF;
        rd(32'h0000_0040, d);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_basic got=%h exp=deadbeef", d); end
        bus.mem_ren = 1'b0; bus.mem_addr = 32'h0000_0044;
        #1;
        total++; if (bus.mem_din !== 32'h0) begin bad++; $display("FAIL ren_low got=%h exp=0", bus.mem_din); end
        tick(1);
    endtask

    task automatic test_ram_random();
        logic [31:0] d;
        logic [9:0]  idx;
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            idx = 10'($urandom_range(0, 1023));
            v   = $urandom;
            wr({20'h0, idx, 2'($urandom)}, v);
            ram_model[int'(idx)] = v;
        end
        foreach (ram_model[k]) begin
            rd({20'h0, 10'(k), 2'b00}, d);
            total++; if (d !== ram_model[k]) begin bad++; $display("FAIL ram_rand idx=%0d got=%h exp=%h", k, d, ram_model[k]); end
            tick(1);
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] old_v;
        logic [31:0] new_v;
        old_v = ram_model[16];
        new_v = $urandom;
        bus.mem_ren = 1'b1; bus.mem_wen = 1'b1;
        bus.mem_addr = 32'h0000_0040; bus.mem_dout = new_v;
        #1;
        total++; if (bus.mem_din !== old_v) begin bad++; $display("FAIL rw_prewrite got=%h exp=%h", bus.mem_din, old_v); end
        @(posedge clk); #1;
        bus.mem_wen = 1'b0;
        #1;
        total++; if (bus.mem_din !== new_v) begin bad++; $display("FAIL rw_postwrite got=%h exp=%h", bus.mem_din, new_v); end
        bus.mem_ren = 1'b0;
        ram_model[16] = new_v;
        tick(1);
    endtask

    task automatic test_timer_reload(input int unsigned cmp);
        logic [31:0] d;
        int unsigned exp_cnt;
        wr(A_CTRL, 32'h0); wr(A_STATUS, 32'h3);
        wr(A_COUNT, 32'h0); wr(A_CMP, cmp); wr(A_CTRL, 32'h7);
        for (int unsigned k = 0; k <= 2 * cmp + 4; k++) begin
            exp_cnt = (k <= cmp) ? k : (k - cmp - 1) % (cmp + 1);
            rd(A_COUNT, d);
            total++; if (d !== exp_cnt) begin bad++; $display("FAIL reload_count cmp=%0d k=%0d got=%0d exp=%0d", cmp, k, d, exp_cnt); end
            total++; if (bus.ir_in !== (k > cmp)) begin bad++; $display("FAIL reload_ir cmp=%0d k=%0d got=%b exp=%b", cmp, k, bus.ir_in, (k > cmp)); end
            total++; if (bus.int_cause !== 1'b0) begin bad++; $display("FAIL reload_cause k=%0d got=%b exp=0", k, bus.int_cause); end
            tick(1);
        end
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL tmr_w1c_ir got=%b exp=0", bus.ir_in); end
    endtask

    task automatic test_timer_oneshot(input int unsigned cmp);
        logic [31:0] d;
        wr(A_CTRL, 32'h0); wr(A_STATUS, 32'h3);
        wr(A_COUNT, 32'h0); wr(A_CMP, cmp); wr(A_CTRL, 32'h1);
        tick(cmp + 4);
        rd(A_COUNT, d);
        total++; if (d !== cmp) begin bad++; $display("FAIL oneshot_count cmp=%0d got=%0d exp=%0d", cmp, d, cmp); end
        rd(A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=0", d); end
        rd(A_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL oneshot_status got=%h exp=1", d); end
        total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL oneshot_ir got=%b exp=0", bus.ir_in); end
        tick(1);
    endtask

    task automatic test_count_write();
        logic [31:0] d;
        wr(A_CTRL, 32'h0); wr(A_STATUS, 32'h3);
        wr(A_CMP, 32'd1000); wr(A_COUNT, 32'h0); wr(A_CTRL, 32'h1);
        tick(3);
        wr(A_COUNT, 32'hFFFF_FFFE);
        rd(A_COUNT, d);
        total++; if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cnt_write got=%h exp=fffffffe", d); end
        tick(1);
        rd(A_COUNT, d);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_inc got=%h exp=ffffffff", d); end
        tick(1);
        rd(A_COUNT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL cnt_wrap got=%h exp=0", d); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_ext_irq();
        logic [31:0] d;
        wr(A_CTRL, 32'h0); wr(A_STATUS, 32'h3);
        tick(3);
        ext_irq = 1'b1;
        tick(2);
        total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL ext_early got=%b exp=0", bus.ir_in); end
        ext_irq = 1'b0;
        tick(1);
        total++; if (bus.ir_in !== 1'b1) begin bad++; $display("FAIL ext_ir got=%b exp=1", bus.ir_in); end
        total++; if (bus.int_cause !== 1'b1) begin bad++; $display("FAIL ext_cause got=%b exp=1", bus.int_cause); end
        rd(A_STATUS, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL ext_status got=%h exp=2", d); end
        wr(A_STATUS, 32'h2);
        total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL ext_w1c got=%b exp=0", bus.ir_in); end
        tick(4);
        ext_irq = 1'b1;
        tick(2);
        ext_irq = 1'b0;
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL set_beats_w1c got=%h exp=2", d); end
        total++; if (bus.ir_in !== 1'b1) begin bad++; $display("FAIL set_beats_w1c_ir got=%b exp=1", bus.ir_in); end
        tick(4);
        wr(A_STATUS, 32'h2);
    endtask

    task automatic test_led();
        logic [31:0] d;
        logic [31:0] v;
        wr(A_LED, 32'h0000_00A5);
        total++; if (led !== 16'h00A5) begin bad++; $display("FAIL led_fixed got=%h exp=00a5", led); end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            wr(A_LED, v);
            total++; if (led !== v[15:0]) begin bad++; $display("FAIL led_port got=%h exp=%h", led, v[15:0]); end
            rd(A_LED, d);
            total++; if (d !== {16'h0, v[15:0]}) begin bad++; $display("FAIL led_read got=%h exp=%h", d, {16'h0, v[15:0]}); end
        end
        wr(A_LED, 32'h0000_00A5);
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        rd(32'h1000_0000, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", d); end
        wr(32'h1000_0040, $urandom);
        rd(32'h0000_0040, d);
        total++; if (d !== ram_model[16]) begin bad++; $display("FAIL unmapped_alias got=%h exp=%h", d, ram_model[16]); end
        rd(32'hFFFF_FF14, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mmio_hole got=%h exp=0", d); end
        wr(32'hFFFF_FE10, 32'h0000_1234);
        total++; if (led !== 16'h00A5) begin bad++; $display("FAIL near_mmio_wr got=%h exp=00a5", led); end
        tick(1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(A_LED, 32'hFFFF); wr(A_STATUS, 32'h3);
        wr(A_CMP, 32'd2); wr(A_COUNT, 32'h0); wr(A_CTRL, 32'h7);
        tick(5);
        total++; if (bus.ir_in !== 1'b1) begin bad++; $display("FAIL pre_reset_ir got=%b exp=1", bus.ir_in); end
        bus.mem_ren = 1'b1; bus.mem_addr = A_COUNT;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL mid_reset_ir got=%b exp=0", bus.ir_in); end
        total++; if (led !== 16'h0) begin bad++; $display("FAIL mid_reset_led got=%h exp=0", led); end
        total++; if (bus.mem_din !== 32'h0) begin bad++; $display("FAIL mid_reset_din got=%h exp=0", bus.mem_din); end
        bus.mem_ren = 1'b0;
        #2 rst_n = 1'b1;
        tick(2);
        rd(A_COUNT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_count got=%h exp=0", d); end
        rd(A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_ctrl got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_ram_random();
        test_rw_same_cycle();
        test_timer_reload(5);
        test_timer_reload($urandom_range(2, 20));
        test_timer_oneshot(3);
        test_timer_oneshot($urandom_range(1, 30));
        test_count_write();
        test_ext_irq();
        test_led();
        test_unmapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
